key_debounce_pulse: RTL and testbench
=====================================

KEY_DEBOUNCE_PULSE -- requirements
Module: key_debounce_pulse

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20: consecutive stable synchronized samples required to accept a level change; legal range 1..65535.
REQ-002 Parameter KEY_ACTIVE_LOW, default 1: 1 means KEY=0 is pressed; 0 means KEY=1 is pressed.
REQ-003 Parameter REPEAT_CYCLES, default 1000: auto-repeat interval in cycles; used only when the repeat feature is compiled in; legal range 1..65535.
REQ-004 CLK  in  1  single clock; all state updates on its rising edge.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 KEY  in  1  raw asynchronous bouncy pushbutton level.
REQ-007 SP  out  1  one-cycle start pulse to the downstream step-pulse generator.
REQ-008 KEY_LEVEL  out  1  debounced pressed level (1 = pressed).
REQ-009 PRESS_CNT  out  8  count of SP pulses issued; wraps 255 -> 0.

Function
REQ-010 KEY shall pass through a two-flop synchronizer; only the second flop output, normalized by KEY_ACTIVE_LOW to "pressed", shall be used by the FSM.
REQ-011 FSM states: IDLE, PRESS_CHK, HELD, REL_CHK; the debounce counter width is clog2(DEBOUNCE_CYCLES+1).
REQ-012 IDLE: pressed -> PRESS_CHK with counter cleared; otherwise stay.
REQ-013 PRESS_CHK: not pressed -> IDLE (glitch rejected, no SP); pressed with counter == DEBOUNCE_CYCLES-1 -> HELD; otherwise counter increments.
REQ-014 HELD: not pressed -> REL_CHK with counter cleared.
REQ-015 REL_CHK: pressed -> HELD with no SP; not pressed with counter == DEBOUNCE_CYCLES-1 -> IDLE; otherwise counter increments.
REQ-016 SP is registered and high for exactly one cycle after each PRESS_CHK -> HELD transition; the REL_CHK -> HELD transition never pulses SP.
REQ-017 Latency: KEY pressed and stable from before edge N -> SP high in the cycle following edge N+DEBOUNCE_CYCLES+2.
REQ-018 KEY_LEVEL is registered; it is 1 in HELD and REL_CHK and 0 in IDLE and PRESS_CHK.
REQ-019 PRESS_CNT increments in the same edge that raises SP, with 8-bit wrap-around.
REQ-020 SP is never high in two consecutive cycles.

Reset
REQ-021 While RST=1 at an edge: state=IDLE, counters=0, synchronizer flops=released level, SP=0, KEY_LEVEL=0, PRESS_CNT=0.
REQ-022 If the key is held through RST deassertion, a full debounce is required and one SP is then produced; RST asserted mid-debounce aborts it with no SP.

Configuration
REQ-023 Macro AUTO_REPEAT_EN defined: a hold counter clears on every entry to HELD and counts cycles in HELD; at REPEAT_CYCLES-1 it issues SP, increments PRESS_CNT, and clears; it is frozen in REL_CHK.
REQ-024 Macro AUTO_REPEAT_EN undefined: exactly one SP per accepted press, no hold counter logic, and REPEAT_CYCLES is ignored.

Structure
REQ-025 Package single_pulse_pkg holds the FSM state enum typedef and the PRESS_CNT width constant (8).
REQ-026 Sub-module sync_2ff (1-bit two-flop synchronizer with a reset value parameter) is instantiated once for KEY.

Verification (DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=0, REPEAT_CYCLES=6)
REQ-027 Clean press: KEY 0->1 before edge 10, held 20 cycles -> SP high only in the cycle after edge 16; KEY_LEVEL=1 from edge 16; PRESS_CNT=1.
REQ-028 Glitch: KEY high for 3 cycles, then low -> SP stays 0, KEY_LEVEL stays 0, PRESS_CNT=0.
REQ-029 Bounce: press accepted, then KEY low for 2 cycles during hold, then high again -> no second SP; KEY_LEVEL stays 1; PRESS_CNT=1.
REQ-030 Reset mid-debounce: RST=1 for 1 cycle two edges into PRESS_CHK with KEY held -> no SP during reset; after release, SP follows 6 edges later (DEBOUNCE_CYCLES+2); PRESS_CNT=1.
REQ-031 Wrap: 256 clean presses -> PRESS_CNT returns to 0; each SP lasts 1 cycle.
REQ-032 AUTO_REPEAT_EN defined, KEY held 20 cycles after acceptance -> SP at acceptance and then every 6 cycles (3 repeats); PRESS_CNT=4. With the macro undefined, PRESS_CNT=1.

Source files
------------

// File: rtl/single_pulse_pkg.sv
// Shared types and constants for the key debounce / single-pulse block.
package single_pulse_pkg;

  // Debounce FSM states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_CHK,
    ST_HELD,
    ST_REL_CHK
  } key_state_e;

  // Width of the press counter output
  localparam int unsigned PRESS_CNT_W = 8;

endpackage : single_pulse_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// The flops reset to RST_VAL so a released input looks idle after reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the raw input through two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops with synchronous reset to the idle level
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule : sync_2ff

// File: rtl/key_debounce_pulse.sv
// Pushbutton debouncer producing a one-cycle start pulse per accepted press.
// Optional auto-repeat while held is compiled in with `define AUTO_REPEAT_EN;
// without it REPEAT_CYCLES is only range-checked.
module key_debounce_pulse
  import single_pulse_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1,
  parameter int unsigned REPEAT_CYCLES   = 1000
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   KEY,
  output logic                   SP,
  output logic                   KEY_LEVEL,
  output logic [PRESS_CNT_W-1:0] PRESS_CNT
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("key_debounce_pulse: DEBOUNCE_CYCLES must be in 1..65535");
  end
  if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 65535) begin : g_bad_repeat
    $error("key_debounce_pulse: REPEAT_CYCLES must be in 1..65535");
  end

  logic key_sync;
  logic pressed;

  key_state_e             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   sp_q, sp_d;
  logic                   key_level_q, key_level_d;
  logic [PRESS_CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic                   accept_sp;

  sync_2ff #(
    .RST_VAL(KEY_ACTIVE_LOW)
  ) u_key_sync (
    .clk(CLK),
    .rst(RST),
    .d  (KEY),
    .q  (key_sync)
  );

  assign pressed = KEY_ACTIVE_LOW ? ~key_sync : key_sync;

  // Debounce FSM: next state, debounce counter and acceptance pulse
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept_sp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pressed) begin
          state_d = ST_PRESS_CHK;
          cnt_d   = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!pressed) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_HELD;
          accept_sp = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_d = ST_REL_CHK;
          cnt_d   = '0;
        end
      end
      ST_REL_CHK: begin
        if (pressed) begin
          state_d = ST_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef AUTO_REPEAT_EN
  localparam int unsigned HOLD_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(REPEAT_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              repeat_sp;

  // Hold counter: cleared on entry to HELD, counts while staying in HELD,
  // frozen elsewhere. A repeat that would land right after another pulse
  // is dropped so SP never stays high two cycles running.
  always_comb begin
    hold_d    = hold_q;
    repeat_sp = 1'b0;
    if (state_q != ST_HELD && state_d == ST_HELD) begin
      hold_d = '0;
    end else if (state_q == ST_HELD && state_d == ST_HELD) begin
      if (hold_q == HOLD_LAST) begin
        hold_d    = '0;
        repeat_sp = ~sp_q;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  // Hold counter register
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end

  // Output pulse, level and press count next values
  always_comb begin
    sp_d        = accept_sp | repeat_sp;
    key_level_d = (state_d == ST_HELD) || (state_d == ST_REL_CHK);
    press_cnt_d = press_cnt_q;
    if (sp_d) begin
      press_cnt_d = press_cnt_q + 1'b1;
    end
  end
`else
  // Output pulse, level and press count next values
  always_comb begin
    sp_d        = accept_sp;
    key_level_d = (state_d == ST_HELD) || (state_d == ST_REL_CHK);
    press_cnt_d = press_cnt_q;
    if (sp_d) begin
      press_cnt_d = press_cnt_q + 1'b1;
    end
  end
`endif

  // State, counters and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sp_q        <= 1'b0;
      key_level_q <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sp_q        <= sp_d;
      key_level_q <= key_level_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign SP        = sp_q;
  assign KEY_LEVEL = key_level_q;
  assign PRESS_CNT = press_cnt_q;

endmodule : key_debounce_pulse

// File: tb/tb_key_debounce_pulse.sv
// Directed self-checking bench for key_debounce_pulse
// (DEBOUNCE_CYCLES=4, KEY_ACTIVE_LOW=0, REPEAT_CYCLES=6).
module tb_key_debounce_pulse;

`ifdef AUTO_REPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic       KEY;
  logic       SP;
  logic       KEY_LEVEL;
  logic [7:0] PRESS_CNT;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_cnt = 8'd0;

  always #5 CLK = ~CLK;

  key_debounce_pulse #(
    .DEBOUNCE_CYCLES(4),
    .KEY_ACTIVE_LOW (1'b0),
    .REPEAT_CYCLES  (6)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .KEY      (KEY),
    .SP       (SP),
    .KEY_LEVEL(KEY_LEVEL),
    .PRESS_CNT(PRESS_CNT)
  );

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    KEY = 1'b0;
    step();
    step();
    RST = 1'b0;
    exp_cnt = 8'd0;
    repeat (4) step();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    KEY = 1'b1;
    repeat (3) step();
    checks++;
    if (SP !== 1'b0) begin errors++; $display("FAIL reset_sp: got %b expected 0", SP); end
    checks++;
    if (KEY_LEVEL !== 1'b0) begin errors++; $display("FAIL reset_level: got %b expected 0", KEY_LEVEL); end
    checks++;
    if (PRESS_CNT !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", PRESS_CNT); end
    KEY = 1'b0;
    RST = 1'b0;
    exp_cnt = 8'd0;
    repeat (8) step();
    checks++;
    if (SP !== 1'b0 || KEY_LEVEL !== 1'b0 || PRESS_CNT !== 8'd0) begin
      errors++;
      $display("FAIL reset_idle: got sp=%b lvl=%b cnt=%0d expected 0/0/0", SP, KEY_LEVEL, PRESS_CNT);
    end
  endtask

  // Press lengths 3 and 4 are rejected, 5 is the shortest accepted press
  task automatic test_glitch();
    int lens[3] = '{3, 4, 5};
    for (int li = 0; li < 3; li++) begin
      for (int k = 0; k < 14; k++) begin
        logic exp_sp, exp_lvl;
        KEY = (k < lens[li]);
        step();
        exp_sp  = (lens[li] == 5) && (k == 6);
        exp_lvl = (lens[li] == 5) && (k >= 6) && (k <= 10);
        if (exp_sp) exp_cnt = exp_cnt + 8'd1;
        checks++;
        if (SP !== exp_sp) begin
          errors++; $display("FAIL glitch_sp len=%0d k=%0d: got %b expected %b", lens[li], k, SP, exp_sp);
        end
        checks++;
        if (KEY_LEVEL !== exp_lvl) begin
          errors++; $display("FAIL glitch_level len=%0d k=%0d: got %b expected %b", lens[li], k, KEY_LEVEL, exp_lvl);
        end
      end
      repeat (4) step();
      checks++;
      if (PRESS_CNT !== exp_cnt) begin
        errors++; $display("FAIL glitch_cnt len=%0d: got %0d expected %0d", lens[li], PRESS_CNT, exp_cnt);
      end
    end
  endtask

  // Held for hold_cycles after KEY rises; returns to idle afterwards
  task automatic test_clean_press(input int hold_cycles, input string tag);
    KEY = 1'b1;
    for (int k = 0; k < hold_cycles; k++) begin
      logic exp_sp, exp_lvl;
      step();
      exp_sp  = (k == 6) || (AUTO && k > 6 && ((k - 6) % 6 == 0));
      exp_lvl = (k >= 6);
      if (exp_sp) exp_cnt = exp_cnt + 8'd1;
      checks++;
      if (SP !== exp_sp) begin
        errors++; $display("FAIL %s_sp k=%0d: got %b expected %b", tag, k, SP, exp_sp);
      end
      checks++;
      if (KEY_LEVEL !== exp_lvl) begin
        errors++; $display("FAIL %s_level k=%0d: got %b expected %b", tag, k, KEY_LEVEL, exp_lvl);
      end
    end
    KEY = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic exp_lvl;
      step();
      exp_lvl = (k < 6);
      checks++;
      if (SP !== 1'b0) begin
        errors++; $display("FAIL %s_rel_sp k=%0d: got %b expected 0", tag, k, SP);
      end
      checks++;
      if (KEY_LEVEL !== exp_lvl) begin
        errors++; $display("FAIL %s_rel_level k=%0d: got %b expected %b", tag, k, KEY_LEVEL, exp_lvl);
      end
    end
    checks++;
    if (PRESS_CNT !== exp_cnt) begin
      errors++; $display("FAIL %s_cnt: got %0d expected %0d", tag, PRESS_CNT, exp_cnt);
    end
  endtask

  // Two low cycles while held must not re-trigger
  task automatic test_bounce();
    for (int k = 0; k < 15; k++) begin
      logic exp_sp, exp_lvl;
      KEY = !(k == 8 || k == 9);
      step();
      exp_sp  = (k == 6);
      exp_lvl = (k >= 6);
      if (exp_sp) exp_cnt = exp_cnt + 8'd1;
      checks++;
      if (SP !== exp_sp) begin
        errors++; $display("FAIL bounce_sp k=%0d: got %b expected %b", k, SP, exp_sp);
      end
      checks++;
      if (KEY_LEVEL !== exp_lvl) begin
        errors++; $display("FAIL bounce_level k=%0d: got %b expected %b", k, KEY_LEVEL, exp_lvl);
      end
    end
    KEY = 1'b0;
    repeat (10) step();
    checks++;
    if (PRESS_CNT !== exp_cnt || KEY_LEVEL !== 1'b0) begin
      errors++; $display("FAIL bounce_end: got cnt=%0d lvl=%b expected cnt=%0d lvl=0", PRESS_CNT, KEY_LEVEL, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_debounce();
    KEY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (SP !== 1'b0) begin errors++; $display("FAIL rstmid_pre_sp k=%0d: got %b expected 0", k, SP); end
    end
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_cnt = 8'd0;
    checks++;
    if (SP !== 1'b0 || KEY_LEVEL !== 1'b0 || PRESS_CNT !== 8'd0) begin
      errors++;
      $display("FAIL rstmid_in_reset: got sp=%b lvl=%b cnt=%0d expected 0/0/0", SP, KEY_LEVEL, PRESS_CNT);
    end
    for (int j = 1; j <= 9; j++) begin
      logic exp_sp, exp_lvl;
      step();
      exp_sp  = (j == 7);
      exp_lvl = (j >= 7);
      if (exp_sp) exp_cnt = exp_cnt + 8'd1;
      checks++;
      if (SP !== exp_sp) begin
        errors++; $display("FAIL rstmid_sp j=%0d: got %b expected %b", j, SP, exp_sp);
      end
      checks++;
      if (KEY_LEVEL !== exp_lvl) begin
        errors++; $display("FAIL rstmid_level j=%0d: got %b expected %b", j, KEY_LEVEL, exp_lvl);
      end
    end
    checks++;
    if (PRESS_CNT !== 8'd1) begin
      errors++; $display("FAIL rstmid_cnt: got %0d expected 1", PRESS_CNT);
    end
    KEY = 1'b0;
    repeat (10) step();
  endtask

  task automatic test_wrap();
    int   pulses = 0;
    logic prev_sp = 1'b0;
    do_reset();
    for (int p = 0; p < 256; p++) begin
      for (int k = 0; k < 16; k++) begin
        KEY = (k < 8);
        step();
        if (SP === 1'b1) begin
          pulses++;
          checks++;
          if (prev_sp !== 1'b0) begin
            errors++; $display("FAIL wrap_pulse_width press=%0d k=%0d: got sp high 2 cycles expected 1", p, k);
          end
        end
        prev_sp = SP;
      end
      if (p == 254) begin
        checks++;
        if (PRESS_CNT !== 8'd255) begin
          errors++; $display("FAIL wrap_cnt_255: got %0d expected 255", PRESS_CNT);
        end
      end
    end
    checks++;
    if (pulses != 256) begin
      errors++; $display("FAIL wrap_pulses: got %0d expected 256", pulses);
    end
    checks++;
    if (PRESS_CNT !== 8'd0) begin
      errors++; $display("FAIL wrap_cnt: got %0d expected 0", PRESS_CNT);
    end
  endtask

  // Held 20 cycles past acceptance: repeats only when compiled in
  task automatic test_auto_repeat();
    do_reset();
    test_clean_press(26, "repeat");
    checks++;
    if (PRESS_CNT !== (AUTO ? 8'd4 : 8'd1)) begin
      errors++; $display("FAIL repeat_total: got %0d expected %0d", PRESS_CNT, AUTO ? 4 : 1);
    end
  endtask

  initial begin
    RST = 1'b1;
    KEY = 1'b0;
    test_reset();
    test_glitch();
    test_clean_press(20, "clean");
    test_bounce();
    test_reset_mid_debounce();
    test_wrap();
    test_auto_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_key_debounce_pulse
